diff_tx: RTL and testbench

Pulse-width transmitter that serialises a 26-bit code onto a single line for `diff_rx`. Each frame has three parts:
- a low/high sync period,
- 26 pulse-width-coded data bits, sent MSB first,
- a low trailer, after which the line returns to its idle-high level.

It sits between the code source logic and the output pin, and is the transmit end of the link that `diff_rx` decodes.

---
 rtl/diff_tx_if.sv | 11 +
 rtl/diff_tx.sv | 144 ++++++++++++++
 tb/tb_diff_tx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/diff_tx_if.sv
// Bus between the code source and the diff_tx pulse-width transmitter.
// The master drives the code and trigger; the slave (diff_tx) drives the line and busy flag.
interface diff_tx_if;
    logic [25:0] code_in;
    logic        trigger_in;
    logic        data_out;
    logic        busy_out;

    modport master (output code_in, output trigger_in, input data_out, input busy_out);
    modport slave  (input code_in, input trigger_in, output data_out, output busy_out);
endinterface

// File: rtl/diff_tx.sv
// Pulse-width transmitter: sync low/high, 26 MSB-first width-coded bits, low trailer.
// Define DIFF_TX_GAP_EN to add a DATA_PERIOD idle-high gap (busy held) after each frame.
module diff_tx #(
    parameter int DATA_PERIOD               = 20,
    parameter int HALF_DATA_PERIOD          = 10,
    parameter int QUARTER_DATA_PERIOD       = 5,
    parameter int THREE_QUARTER_DATA_PERIOD = 15
) (
    input  logic     clk_in,
    input  logic     rst_in,
    diff_tx_if.slave bus
);
    localparam int CW = $clog2(DATA_PERIOD + 1);

    localparam logic [CW-1:0] DP_C   = CW'(DATA_PERIOD);
    localparam logic [CW-1:0] HALF_C = CW'(HALF_DATA_PERIOD);
    localparam logic [CW-1:0] QTR_C  = CW'(QUARTER_DATA_PERIOD);
    localparam logic [CW-1:0] TQTR_C = CW'(THREE_QUARTER_DATA_PERIOD);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SYNC_L = 3'd1;
    localparam logic [2:0] S_SYNC_H = 3'd2;
    localparam logic [2:0] S_BIT_L  = 3'd3;
    localparam logic [2:0] S_BIT_H  = 3'd4;
    localparam logic [2:0] S_END_L  = 3'd5;
    localparam logic [2:0] S_GAP    = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [4:0]    idx_q,   idx_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [25:0]   code_q,  code_d;
    logic          data_q,  data_d;
    logic          busy_q,  busy_d;

    logic [CW-1:0] bit_lo;
    logic [CW-1:0] phase_len;
    logic          phase_done;

    // Low phase width of the bit in flight; the high phase is its complement.
    assign bit_lo = code_q[idx_q] ? TQTR_C : QTR_C;

    always_comb begin
        phase_len = HALF_C;
        case (state_q)
            S_BIT_L: phase_len = bit_lo;
            S_BIT_H: phase_len = DP_C - bit_lo;
            S_GAP:   phase_len = DP_C;
            default: phase_len = HALF_C;
        endcase
    end

    assign phase_done = (cnt_q == phase_len);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        data_d  = data_q;
        busy_d  = busy_q;

        if (state_q != S_IDLE) begin
            cnt_d = phase_done ? ONE_C : cnt_q + ONE_C;
        end

        case (state_q)
            S_IDLE: begin
                data_d = 1'b1;
                if (bus.trigger_in) begin
                    code_d  = bus.code_in;
                    idx_d   = 5'd25;
                    cnt_d   = ONE_C;
                    data_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SYNC_L;
                end
            end
            S_SYNC_L: if (phase_done) begin
                data_d  = 1'b1;
                state_d = S_SYNC_H;
            end
            S_SYNC_H: if (phase_done) begin
                data_d  = 1'b0;
                state_d = S_BIT_L;
            end
            S_BIT_L: if (phase_done) begin
                data_d  = 1'b1;
                state_d = S_BIT_H;
            end
            S_BIT_H: if (phase_done) begin
                data_d = 1'b0;
                if (idx_q == 5'd0) begin
                    state_d = S_END_L;
                end else begin
                    idx_d   = idx_q - 5'd1;
                    state_d = S_BIT_L;
                end
            end
            S_END_L: if (phase_done) begin
                data_d = 1'b1;
`ifdef DIFF_TX_GAP_EN
                state_d = S_GAP;
`else
                cnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
`endif
            end
            S_GAP: if (phase_done) begin
                cnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                data_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd25;
            cnt_q   <= '0;
            code_q  <= '0;
            data_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.busy_out = busy_q;
endmodule

// File: tb/tb_diff_tx.sv
// Directed bench for diff_tx: per-cycle line/busy waveform against a frame model,
// plus hand-computed spot values, held trigger, and asynchronous reset mid-frame.
module tb_diff_tx;
`ifdef DIFF_TX_GAP_EN
    localparam int BL = 570;
`else
    localparam int BL = 550;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;
    logic smp [0:BL];

    diff_tx_if bus ();

    diff_tx u_dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic logic exp_data(input logic [25:0] c, input int e);
        int k, ph, lo;
        if (e < 10) return 1'b0;
        if (e < 20) return 1'b1;
        if (e < 540) begin
            k  = (e - 20) / 20;
            ph = (e - 20) % 20;
            lo = c[25-k] ? 15 : 5;
            return (ph < lo) ? 1'b0 : 1'b1;
        end
        if (e < 550) return 1'b0;
        return 1'b1;
    endfunction

    // Entered just after accept edge 0; returns at the negedge following edge BL.
    task automatic check_frame(input string tag, input logic [25:0] code, input bit mid,
                               input logic [25:0] mid_code, input int exp_low);
        int bad_d = 0, bad_b = 0, low = 0;
        for (int e = 0; e <= BL; e++) begin
            @(negedge clk);
            if (mid && e == 100) bus.code_in = mid_code;
            smp[e] = bus.data_out;
            if (bus.data_out !== exp_data(code, e)) bad_d++;
            if (bus.busy_out !== (e < BL)) bad_b++;
            if (e >= 20 && e < 540 && bus.data_out === 1'b0) low++;
            if (e < BL) @(posedge clk);
        end
        chk({tag, " line"}, bad_d, 0);
        chk({tag, " busy"}, bad_b, 0);
        chk({tag, " lowcyc"}, low, exp_low);
    endtask

    initial begin
        int bad;
        bus.code_in    = '0;
        bus.trigger_in = 1'b0;

        #12;
        chk("rst data", bus.data_out, 1);
        chk("rst busy", bus.busy_out, 0);
        @(negedge clk) rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.data_out !== 1'b1 || bus.busy_out !== 1'b0) bad++;
        end
        chk("idle quiet", bad, 0);

        // Alternating code: hand-checked edges of sync, bit 25 (1) and bit 24 (0).
        bus.code_in = 26'h2AAAAAA;
        bus.trigger_in = 1'b1;
        @(posedge clk); #1 bus.trigger_in = 1'b0;
        check_frame("alt", 26'h2AAAAAA, 0, '0, 260);
        chk("alt s9",   smp[9],   0);
        chk("alt s10",  smp[10],  1);
        chk("alt s20",  smp[20],  0);
        chk("alt s34",  smp[34],  0);
        chk("alt s35",  smp[35],  1);
        chk("alt s40",  smp[40],  0);
        chk("alt s44",  smp[44],  0);
        chk("alt s45",  smp[45],  1);
        chk("alt s59",  smp[59],  1);
        chk("alt s549", smp[549], 0);
        chk("alt s550", smp[550], 1);

        repeat (3) @(negedge clk);
        bus.code_in = 26'h0000000;
        bus.trigger_in = 1'b1;
        @(posedge clk); #1 bus.trigger_in = 1'b0;
        check_frame("zeros", 26'h0000000, 0, '0, 130);

        repeat (3) @(negedge clk);
        bus.code_in = 26'h3FFFFFF;
        bus.trigger_in = 1'b1;
        @(posedge clk); #1 bus.trigger_in = 1'b0;
        check_frame("ones", 26'h3FFFFFF, 0, '0, 390);

        // Trigger held: second accept is the edge right after busy falls.
        repeat (3) @(negedge clk);
        bus.code_in = 26'h1234567;
        bus.trigger_in = 1'b1;
        @(posedge clk); #1;
        check_frame("held1", 26'h1234567, 1, 26'h3FFFFFF, 250);
        @(posedge clk); #1;
        check_frame("held2", 26'h3FFFFFF, 0, '0, 390);
        bus.trigger_in = 1'b0;

        // Asynchronous reset at edge 200, new frame accepted at edge 210.
        repeat (3) @(negedge clk);
        bus.code_in = 26'h2AAAAAA;
        bus.trigger_in = 1'b1;
        @(posedge clk); #1 bus.trigger_in = 1'b0;
        repeat (200) @(posedge clk);
        #1 chk("pre-rst data", bus.data_out, 0);
        rst = 1'b1;
        #1;
        chk("mid-rst data", bus.data_out, 1);
        chk("mid-rst busy", bus.busy_out, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        bad = 0;
        for (int i = 204; i <= 209; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.data_out !== 1'b1 || bus.busy_out !== 1'b0) bad++;
        end
        chk("post-rst idle", bad, 0);
        bus.code_in = 26'h1234567;
        bus.trigger_in = 1'b1;
        @(posedge clk); #1 bus.trigger_in = 1'b0;
        check_frame("after-rst", 26'h1234567, 0, '0, 250);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
